// File: rtl/sync_fifo_flags_if.sv
// Handshake bundle for sync_fifo_flags: write/read requests, data, occupancy and status flags.
// The master side is the FIFO user; the slave side is the FIFO itself.
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic                  w_inc;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_full;
  logic                  w_afull;
  logic                  r_inc;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_empty;
  logic                  r_aempty;
  logic [ADDR_WIDTH:0]   count;
  logic                  err_clr;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_inc, w_data, r_inc, err_clr,
    input  w_full, w_afull, r_data, r_empty, r_aempty, count, overflow, underflow
  );

  modport slave (
    input  w_inc, w_data, r_inc, err_clr,
    output w_full, w_afull, r_data, r_empty, r_aempty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with full/empty/almost flags, occupancy count and sticky error flags.
// Read port is first-word-fall-through (FWFT=1) or a registered read (FWFT=0).
module sync_fifo_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter bit FWFT          = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_flags_if.slave bus
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0] DEPTH_LVL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_LVL  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_LVL = CNT_W'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [CNT_W-1:0] wptr;
  logic [CNT_W-1:0] rptr;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             w_accept;
  logic             r_accept;

  // The extra pointer MSB distinguishes full from empty, so the modular
  // difference is the exact occupancy across any number of wraps.
  assign occupancy = wptr - rptr;
  assign full      = (occupancy == DEPTH_LVL);
  assign empty     = (occupancy == '0);

  assign w_accept  = bus.w_inc & ~full;
  assign r_accept  = bus.r_inc & ~empty;

  assign bus.count    = occupancy;
  assign bus.w_full   = full;
  assign bus.r_empty  = empty;
  assign bus.w_afull  = (occupancy >= AFULL_LVL);
  assign bus.r_aempty = (occupancy <= AEMPTY_LVL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (w_accept) wptr <= wptr + 1'b1;
      if (r_accept) rptr <= rptr + 1'b1;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_accept) mem[wptr[ADDR_WIDTH-1:0]] <= bus.w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (bus.w_inc && full)       bus.overflow <= 1'b1;
      else if (bus.err_clr)        bus.overflow <= 1'b0;
      if (bus.r_inc && empty)      bus.underflow <= 1'b1;
      else if (bus.err_clr)        bus.underflow <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft_read
      // Head word is visible once its write edge has moved the pointers, never earlier.
      assign bus.r_data = mem[rptr[ADDR_WIDTH-1:0]];
    end else begin : g_reg_read
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        bus.r_data <= '0;
        else if (r_accept) bus.r_data <= mem[rptr[ADDR_WIDTH-1:0]];
      end
    end
  endgenerate

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-2, almost-full level in words.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 2, almost-empty level in words.
REQ-005 SHALL have parameter FWFT, default 1; 1 = first-word-fall-through read, 0 = registered read.
REQ-006 SHALL have ports, in this order:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- w_inc  in  1  write request.
- w_data  in  DATA_WIDTH  write word.
- w_full  out  1  FIFO holds DEPTH words.
- w_afull  out  1  count >= AFULL_THRESH.
- r_inc  in  1  read request.
- r_data  out  DATA_WIDTH  read word.
- r_empty  out  1  FIFO holds 0 words.
- r_aempty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- err_clr  in  1  clears sticky error flags.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
REQ-007 SHALL use one clock only (clk); reset is asynchronous and active-low (rst_n).

Function
REQ-008 SHALL keep binary write and read pointers, ADDR_WIDTH+1 bits each, wrapping modulo 2**(ADDR_WIDTH+1); the low ADDR_WIDTH bits address memory.
REQ-009 SHALL accept a write when w_inc=1 and w_full=0: mem[wptr] <= w_data and wptr += 1 on that edge.
REQ-010 SHALL accept a read when r_inc=1 and r_empty=0: rptr += 1 on that edge.
REQ-011 SHALL derive count = wptr - rptr (modulo 2**(ADDR_WIDTH+1)), w_full = (count == DEPTH), r_empty = (count == 0), w_afull and r_aempty per REQ-006, all from registered state only, with no combinational path from w_inc or r_inc.
REQ-012 SHALL, on simultaneous accepted read and write, leave count unchanged and update both pointers.
REQ-013 SHALL, when full, reject w_inc, accept r_inc on the same cycle, and decrease count by 1.
REQ-014 SHALL, when empty, reject r_inc, accept w_inc on the same cycle, and increase count by 1; the written word SHALL NOT bypass to the reader on that cycle.
REQ-015 SHALL, when FWFT=1, drive r_data combinationally from mem[rptr]; the head word is valid whenever r_empty=0, starting the cycle after its write.
REQ-016 SHALL, when FWFT=0, load r_data register with mem[rptr] on each accepted read (one-cycle latency) and hold it otherwise.
REQ-017 SHALL set overflow on any edge with w_inc=1 and w_full=1, and underflow on any edge with r_inc=1 and r_empty=1; both stay set until err_clr=1.
REQ-018 SHALL give set priority over err_clr when both occur on the same edge.
REQ-019 SHALL produce correct flags across pointer wrap-around for an unbounded number of cycles.

Reset
REQ-020 SHALL, while rst_n=0, asynchronously force wptr=0, rptr=0, overflow=0, underflow=0, and the registered r_data (FWFT=0) to 0; as a result r_empty=1, r_aempty=1, w_full=0, w_afull=0, count=0.
REQ-021 SHALL NOT reset memory contents; a reset asserted mid-operation discards all stored words.
REQ-022 SHALL accept the first write on the first rising edge after rst_n deasserts.

Verification
REQ-023 Reset, then write 0x01..0x10 (DEPTH=16) -> count 16, w_full=1, w_afull asserted at count 14, r_aempty deasserted at count 3.
REQ-024 Full FIFO, w_inc=1 with r_inc=1 for one cycle -> read accepted, write rejected, count 15, overflow=1; then err_clr=1 -> overflow=0.
REQ-025 FWFT=1, empty, write 0xA5 -> r_data=0xA5 and r_empty=0 on the next cycle; r_inc on that cycle -> r_empty=1 and count 0.
REQ-026 FWFT=0, FIFO holding 0x11,0x22, two reads -> r_data=0x11 one cycle after the first read and 0x22 one cycle after the second; r_inc while empty -> underflow=1, r_data holds 0x22.
REQ-027 Continuous simultaneous read and write for 100 cycles at count 5 with incrementing data -> count stays 5, data in order, no errors across pointer wrap.
REQ-028 Assert rst_n=0 mid-stream at count 9 -> count=0, r_empty=1, flags cleared immediately without waiting for a clock edge.
